vend_controller: RTL and testbench

Sequencing FSM for the vending machine.
- Accepts coins into a 4-bit balance and decodes item requests against a per-item price table.
- Computes change with the same rule as the change datapath: refund gives the full balance; vend gives balance − price when balance ≥ price, else 0.
- Pays change out one unit per handshake.
- Sits between the coin/keypad front end and the item/coin dispensers.

---
 rtl/vend_controller_if.sv | 32 +++
 rtl/vend_controller.sv | 171 +++++++++++++++++
 tb/tb_vend_controller.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vend_controller_if.sv
// Handshake bundle between the coin/keypad front end, the vend controller and the dispensers.
// The front end side is the master; the controller side is the slave.
`timescale 1ns/1ps
interface vend_controller_if;
  logic       coin_valid;
  logic [1:0] coin_val;
  logic       item_req;
  logic [1:0] item_sel;
  logic       cancel;
  logic       payout_ready;
  logic       coin_reject;
  logic       insufficient;
  logic       item_valid;
  logic [1:0] item_id;
  logic       payout_pulse;
  logic [3:0] balance;
  logic [3:0] change_total;
  logic       busy;
  logic       txn_done;

  modport master (
    output coin_valid, coin_val, item_req, item_sel, cancel, payout_ready,
    input  coin_reject, insufficient, item_valid, item_id, payout_pulse,
           balance, change_total, busy, txn_done
  );

  modport slave (
    input  coin_valid, coin_val, item_req, item_sel, cancel, payout_ready,
    output coin_reject, insufficient, item_valid, item_id, payout_pulse,
           balance, change_total, busy, txn_done
  );
endinterface

// File: rtl/vend_controller.sv
// Vending machine sequencer: coin credit, item decode against a price table, unit-by-unit change payout.
// Optional inactivity auto-refund in COLLECT is built only when VEND_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module vend_controller #(
  parameter logic [3:0]  PRICE0         = 4'd3,
  parameter logic [3:0]  PRICE1         = 4'd5,
  parameter logic [3:0]  PRICE2         = 4'd7,
  parameter logic [3:0]  PRICE3         = 4'd10,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
  input logic              clk,
  input logic              rst_n,
  vend_controller_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VEND    = 2'd2,
    ST_PAYOUT  = 2'd3
  } state_t;

  localparam logic [15:0] PRICE_PACK = {PRICE3, PRICE2, PRICE1, PRICE0};

  state_t     state_reg;
  logic [3:0] balance_reg;
  logic [3:0] change_total_reg;
  logic [3:0] remaining_reg;
  logic [1:0] item_id_reg;
  logic       coin_reject_reg;
  logic       insufficient_reg;
  logic       item_valid_reg;
  logic       payout_pulse_reg;
  logic       busy_reg;
  logic       txn_done_reg;

  logic [3:0] price_tab [4];
  logic [3:0] price_sel;
  logic [2:0] coin_amt;
  logic [4:0] coin_sum;
  logic       coin_ok;
  logic       afford;
  logic       any_strobe;
  logic       timeout_hit;

  for (genvar gi = 0; gi < 4; gi++) begin : g_price
    assign price_tab[gi] = PRICE_PACK[gi*4 +: 4];
  end

  always_comb begin
    coin_amt = 3'd0;
    case (bus.coin_val)
      2'b00:   coin_amt = 3'd1;
      2'b01:   coin_amt = 3'd2;
      2'b10:   coin_amt = 3'd5;
      default: coin_amt = 3'd0;
    endcase
  end

  assign price_sel  = price_tab[bus.item_sel];
  assign coin_sum   = {1'b0, balance_reg} + {2'b00, coin_amt};
  assign coin_ok    = (bus.coin_val != 2'b11) && (coin_sum <= 5'd15);
  assign afford     = (balance_reg >= price_sel);
  assign any_strobe = bus.cancel || bus.item_req || bus.coin_valid;

`ifdef VEND_TIMEOUT_EN
  logic [15:0] idle_cnt_reg;

  // Counts strobe-free cycles spent in COLLECT; any user strobe restarts it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idle_cnt_reg <= '0;
    end else if (state_reg != ST_COLLECT || any_strobe || timeout_hit) begin
      idle_cnt_reg <= '0;
    end else begin
      idle_cnt_reg <= idle_cnt_reg + 16'd1;
    end
  end

  assign timeout_hit = (state_reg == ST_COLLECT) && !any_strobe &&
                       ((idle_cnt_reg + 16'd1) >= TIMEOUT_CYCLES);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg        <= ST_IDLE;
      balance_reg      <= '0;
      change_total_reg <= '0;
      remaining_reg    <= '0;
      item_id_reg      <= '0;
      coin_reject_reg  <= 1'b0;
      insufficient_reg <= 1'b0;
      item_valid_reg   <= 1'b0;
      payout_pulse_reg <= 1'b0;
      busy_reg         <= 1'b0;
      txn_done_reg     <= 1'b0;
    end else begin
      coin_reject_reg  <= 1'b0;
      insufficient_reg <= 1'b0;
      item_valid_reg   <= 1'b0;
      payout_pulse_reg <= 1'b0;
      txn_done_reg     <= 1'b0;

      case (state_reg)
        ST_IDLE, ST_COLLECT: begin
          // Priority cancel > item_req > coin; a losing coin is bounced.
          if ((bus.cancel && state_reg == ST_COLLECT) || timeout_hit) begin
            change_total_reg <= balance_reg;
            remaining_reg    <= balance_reg;
            balance_reg      <= '0;
            busy_reg         <= 1'b1;
            coin_reject_reg  <= bus.coin_valid;
            state_reg        <= ST_PAYOUT;
          end else if (bus.item_req) begin
            coin_reject_reg <= bus.coin_valid;
            if (afford) begin
              change_total_reg <= balance_reg - price_sel;
              remaining_reg    <= balance_reg - price_sel;
              balance_reg      <= '0;
              item_id_reg      <= bus.item_sel;
              item_valid_reg   <= 1'b1;
              busy_reg         <= 1'b1;
              state_reg        <= ST_VEND;
            end else begin
              insufficient_reg <= 1'b1;
            end
          end else if (bus.coin_valid) begin
            if (coin_ok) begin
              balance_reg <= coin_sum[3:0];
              state_reg   <= ST_COLLECT;
            end else begin
              coin_reject_reg <= 1'b1;
            end
          end
        end

        ST_VEND: begin
          coin_reject_reg <= bus.coin_valid;
          state_reg       <= ST_PAYOUT;
        end

        ST_PAYOUT: begin
          coin_reject_reg <= bus.coin_valid;
          if (remaining_reg == 4'd0) begin
            txn_done_reg <= 1'b1;
            busy_reg     <= 1'b0;
            state_reg    <= ST_IDLE;
          end else if (bus.payout_ready) begin
            payout_pulse_reg <= 1'b1;
            remaining_reg    <= remaining_reg - 4'd1;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.coin_reject  = coin_reject_reg;
  assign bus.insufficient = insufficient_reg;
  assign bus.item_valid   = item_valid_reg;
  assign bus.item_id      = item_id_reg;
  assign bus.payout_pulse = payout_pulse_reg;
  assign bus.balance      = balance_reg;
  assign bus.change_total = change_total_reg;
  assign bus.busy         = busy_reg;
  assign bus.txn_done     = txn_done_reg;

endmodule

// File: tb/tb_vend_controller.sv
// Scoreboard bench for vend_controller: stimulus pushes expected events into per-kind queues,
// a negedge monitor pops and compares whenever the DUT presents an event or a balance change.
`timescale 1ns/1ps
module tb_vend_controller;

  logic clk;
  logic rst_n;
  vend_controller_if bus ();

  vend_controller #(.TIMEOUT_CYCLES(16'd8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state and expectation queues
  int bal = 0;
  int price_tab [4] = '{3, 5, 7, 10};
  int bal_q [$];
  int rej_q [$];
  int ins_q [$];
  int item_id_q [$];
  int item_chg_q [$];
  int pay_q [$];
  int done_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int coin_value(input bit [1:0] code);
    case (code)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 5;
      default: return 0;
    endcase
  endfunction

  // ---------------- monitor ----------------
  logic       ready_at_edge = 1'b0;
  logic       rst_at_edge   = 1'b0;
  logic [3:0] prev_bal      = 4'd0;

  always @(posedge clk) begin
    ready_at_edge <= bus.payout_ready;
    rst_at_edge   <= rst_n;
  end

  always @(negedge clk) begin
    int e;
    if (rst_at_edge !== 1'b1) begin
      prev_bal = bus.balance;
    end else begin
      if (bus.coin_reject === 1'b1) begin
        if (rej_q.size() == 0) check("reject_unexpected", 1, 0);
        else begin e = rej_q.pop_front(); check("reject_balance", bus.balance, e); end
      end
      if (bus.insufficient === 1'b1) begin
        if (ins_q.size() == 0) check("insufficient_unexpected", 1, 0);
        else begin e = ins_q.pop_front(); check("insufficient_balance", bus.balance, e); end
      end
      if (bus.item_valid === 1'b1) begin
        if (item_id_q.size() == 0) check("item_unexpected", 1, 0);
        else begin
          e = item_id_q.pop_front();
          check("item_id", bus.item_id, e);
          e = item_chg_q.pop_front();
          check("item_change_total", bus.change_total, e);
          check("item_busy", bus.busy, 1);
        end
      end
      if (bus.payout_pulse === 1'b1) begin
        if (pay_q.size() == 0) check("payout_unexpected", 1, 0);
        else begin e = pay_q.pop_front(); check("payout_change_total", bus.change_total, e); end
        check("payout_ready_seen", ready_at_edge, 1);
      end
      if (bus.txn_done === 1'b1) begin
        if (done_q.size() == 0) check("done_unexpected", 1, 0);
        else begin
          e = done_q.pop_front();
          check("done_change_total", bus.change_total, e);
          check("done_busy", bus.busy, 0);
        end
      end
      if (bus.balance !== prev_bal) begin
        if (bal_q.size() == 0) check("balance_unexpected", bus.balance, prev_bal);
        else begin e = bal_q.pop_front(); check("balance", bus.balance, e); end
        prev_bal = bus.balance;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_reset_state();
    check("rst_balance", bus.balance, 0);
    check("rst_change_total", bus.change_total, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_payout_pulse", bus.payout_pulse, 0);
    check("rst_item_valid", bus.item_valid, 0);
    check("rst_txn_done", bus.txn_done, 0);
    check("rst_coin_reject", bus.coin_reject, 0);
  endtask

  // mode: 0 random ready, 1 always ready, 2 toggling ready
  task automatic run_payout(input int mode, input bit inject);
    bit done_seen = 0;
    bit tog = 1;
    for (int i = 0; i < 400 && !done_seen; i++) begin
      if (bus.txn_done === 1'b1) begin
        done_seen = 1;
      end else begin
        case (mode)
          1:       bus.payout_ready = 1'b1;
          2:       bus.payout_ready = tog;
          default: bus.payout_ready = 1'($urandom_range(0, 1));
        endcase
        tog = ~tog;
        bus.coin_valid = 1'b0;
        if (inject && $urandom_range(0, 3) == 0) begin
          bus.coin_valid = 1'b1;
          bus.coin_val   = 2'($urandom_range(0, 3));
          rej_q.push_back(0);
        end
        @(posedge clk); #1;
      end
    end
    bus.coin_valid = 1'b0;
    if (!done_seen) check("payout_timeout", 0, 1);
  endtask

  // One strobe cycle; expectations derived from the vending rules, not the FSM.
  task automatic txn(input bit cv, input bit [1:0] code, input bit ir, input bit [1:0] sel,
                     input bit can, input int mode, input bit inject);
    int change = 0;
    bit pay = 0;
    int v;
    if (can && bal > 0) begin
      change = bal;
      pay = 1;
    end else if (ir) begin
      if (bal >= price_tab[sel]) begin
        change = bal - price_tab[sel];
        pay = 1;
        item_id_q.push_back(int'(sel));
        item_chg_q.push_back(change);
      end else begin
        ins_q.push_back(bal);
      end
    end
    if (pay) begin
      if (bal != 0) bal_q.push_back(0);
      bal = 0;
      repeat (change) pay_q.push_back(change);
      done_q.push_back(change);
    end
    if (cv) begin
      v = coin_value(code);
      if (pay || ir || code == 2'b11 || bal + v > 15) rej_q.push_back(bal);
      else begin
        bal = bal + v;
        bal_q.push_back(bal);
      end
    end
    bus.coin_valid = cv;
    bus.coin_val   = code;
    bus.item_req   = ir;
    bus.item_sel   = sel;
    bus.cancel     = can;
    @(posedge clk); #1;
    bus.coin_valid = 1'b0;
    bus.item_req   = 1'b0;
    bus.cancel     = 1'b0;
    if (pay) run_payout(mode, inject);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen;
    int r;
    bit [1:0] code;
    bit [1:0] sel;
    rst_n = 1'b0;
    bus.coin_valid = 1'b0; bus.coin_val = 2'b00; bus.item_req = 1'b0;
    bus.item_sel = 2'b00; bus.cancel = 1'b0; bus.payout_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state();
    rst_n = 1'b1;
    idle(2);

    // Coins 5,5 then item 2 (price 7): change 3
    txn(1, 2'b10, 0, 0, 0, 1, 0);
    txn(1, 2'b10, 0, 0, 0, 1, 0);
    txn(0, 2'b00, 1, 2, 0, 1, 0);
    idle(2);

    // Fill to 15, overflow and invalid coin rejected, then refund
    txn(1, 2'b10, 0, 0, 0, 0, 0);
    txn(1, 2'b10, 0, 0, 0, 0, 0);
    txn(1, 2'b10, 0, 0, 0, 0, 0);
    txn(1, 2'b00, 0, 0, 0, 0, 0);
    txn(1, 2'b11, 0, 0, 0, 0, 0);
    txn(0, 2'b00, 0, 0, 1, 0, 1);
    txn(1, 2'b11, 0, 0, 0, 0, 0);
    idle(1);

    // Balance 4, item 1 insufficient, cancel refunds 4
    txn(1, 2'b01, 0, 0, 0, 1, 0);
    txn(1, 2'b01, 0, 0, 0, 1, 0);
    txn(0, 2'b00, 1, 1, 0, 1, 0);
    txn(0, 2'b00, 0, 0, 1, 1, 0);
    idle(1);

    // Balance 6, simultaneous cancel+item+coin; ready toggling
    txn(1, 2'b10, 0, 0, 0, 0, 0);
    txn(1, 2'b00, 0, 0, 0, 0, 0);
    txn(1, 2'b00, 1, 0, 1, 2, 0);
    idle(2);

    // Reset during payout with 2 units remaining
    txn(1, 2'b10, 0, 0, 0, 0, 0);
    bal_q.push_back(0);
    repeat (5) pay_q.push_back(5);
    done_q.push_back(5);
    bal = 0;
    bus.payout_ready = 1'b1;
    bus.cancel = 1'b1;
    @(posedge clk); #1;
    bus.cancel = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && seen < 3; i++) begin
      @(posedge clk); #1;
      if (bus.payout_pulse === 1'b1) seen++;
    end
    check("pulses_before_reset", seen, 3);
    rst_n = 1'b0;
    @(posedge clk); #1;
    pay_q.delete();
    done_q.delete();
    check_reset_state();
    rst_n = 1'b1;
    idle(6);

`ifdef VEND_TIMEOUT_EN
    // Auto refund after 8 idle cycles; a coin at cycle 7 restarts the count
    txn(1, 2'b01, 0, 0, 0, 1, 0);
    idle(6);
    txn(1, 2'b00, 0, 0, 0, 1, 0);
    idle(7);
    bal_q.push_back(0);
    repeat (3) pay_q.push_back(3);
    done_q.push_back(3);
    bal = 0;
    run_payout(1, 0);
    idle(2);
    txn(1, 2'b01, 0, 0, 0, 1, 0);
    idle(7);
    bal_q.push_back(0);
    repeat (2) pay_q.push_back(2);
    done_q.push_back(2);
    bal = 0;
    run_payout(1, 0);
    idle(2);
`endif

    // Randomized traffic
    for (int n = 0; n < 250; n++) begin
      r    = int'($urandom_range(0, 9));
      code = 2'($urandom_range(0, 3));
      sel  = 2'($urandom_range(0, 3));
      if (r < 5)      txn(1, code, 0, sel, 0, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      else if (r < 7) txn(0, code, 1, sel, 0, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      else if (r < 8) txn(0, code, 0, sel, 1, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      else            txn(1, code, 1'($urandom_range(0, 1)), sel, 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      idle(int'($urandom_range(0, 3)));
    end

    idle(4);
    check("left_balance", bal_q.size(), 0);
    check("left_reject", rej_q.size(), 0);
    check("left_insufficient", ins_q.size(), 0);
    check("left_item", item_id_q.size(), 0);
    check("left_payout", pay_q.size(), 0);
    check("left_done", done_q.size(), 0);
    check("final_balance", bus.balance, bal);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
